fifo_tx_drain: RTL
==================

Name: fifo_tx_drain

Overview:
- Consumer for the 16x16 synchronous FIFO.
- Pops one word at a time through the FIFO read port and transmits it on a single serial line. Framing is UART-style: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), each bit held CLKS_PER_BIT clocks.
- Sits between the FIFO's output side and an off-chip or inter-block serial link.

Parameters:
- DATA_WIDTH, 16, width of fifo_out and of each serial data payload.
- CLKS_PER_BIT, 4, clocks per serial bit; legal range 2..65535.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  permits starting new words; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_out  input  DATA_WIDTH  FIFO read data; registered in FIFO, valid the cycle after the popping edge.
- fifo_read  output  1  registered pop strobe to FIFO; high exactly one cycle per word.
- tx_serial  output  1  serial data line; idles high.
- busy  output  1  high in every state except IDLE.
- words_sent  output  16  count of completed frames; wraps 16'hFFFF->0.

Behaviour:
- Reset (clock and reset are synchronous, active-high): at the next edge, state=IDLE, tx_serial=1, fifo_read=0, busy=0, words_sent=0, bit counter=0, clock-divide counter=0.
- Reset mid-frame: the word in flight is discarded. Nothing is re-read.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, READ, LOAD, START, DATA, STOP.
- IDLE: tx_serial=1. If enable=1 and fifo_empty=0 at an edge -> READ, with fifo_read=1 for the following cycle. Otherwise stay.
- READ: lasts 1 cycle with fifo_read=1, so the FIFO pops at the end edge. -> LOAD; fifo_read returns to 0.
- LOAD: lasts 1 cycle. At its end edge, shift register <= fifo_out, tx_serial <= 0, divide counter <= 0 -> START.
- START: tx_serial=0 for CLKS_PER_BIT cycles -> DATA; tx_serial <= shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit counter increments.
  - After bit DATA_WIDTH-1 completes -> STOP; tx_serial <= 1.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles. On the final edge, words_sent increments.
  - Next state is READ (fifo_read=1) if enable=1 and fifo_empty=0; otherwise IDLE.
- Timing:
  - Latency from the IDLE decision edge to the falling start-bit edge is 2 clocks.
  - Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT clocks.
  - Back-to-back gap between a stop-bit end and the next start bit is 2 clocks high (READ, LOAD).
- fifo_empty and enable are sampled only in IDLE and on the last STOP cycle.
- A FIFO that goes empty after the pop does not affect the current frame.
- Never asserts fifo_read while fifo_empty=1 at the decision edge, so there is no underflow.
- enable deasserted mid-frame: the current frame completes normally; the block then goes to IDLE.
- busy=1 from the READ entry edge through the last STOP cycle.

Test Plan:
- Reset: assert reset 2 cycles with garbage inputs -> tx_serial=1, fifo_read=0, busy=0, words_sent=0 on the cycle after the first reset edge.
- Single word: FIFO holds 16'hA5C3, CLKS_PER_BIT=4, enable=1 -> exactly one fifo_read pulse.
  - tx_serial low 4 clocks from 2 clocks after the decision edge.
  - Then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each 4 clocks.
  - Then high 4 clocks; words_sent=1; back to IDLE; frame total 72 clocks.
- Back-to-back: FIFO preloaded with 16'h0001, 16'hFFFF, 16'h8000 -> 3 fifo_read pulses spaced 74 clocks apart; 2-clock high gap between frames; decoded words match in order; words_sent=3; then IDLE with fifo_empty=1 and no further reads.
- Empty and enable gating:
  - enable=1 with fifo_empty=1 for 100 clocks -> no fifo_read, tx_serial=1.
  - Drop enable during data bit 5 of a frame -> frame completes, no next read even though the FIFO is non-empty.
- Reset mid-frame: reset during data bit 8 -> tx_serial=1 next cycle, words_sent=0, state IDLE. With enable=1 and the FIFO non-empty afterwards, the next word (not the aborted one) is popped and sent intact.
- Wrap: force words_sent to 16'hFFFF via preload/backdoor and send one word -> words_sent=0.

Source files
------------

// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain: pops FIFO words and sends each as a UART-style frame on tx_serial
module fifo_tx_drain #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  fifo_read,
  output logic                  tx_serial,
  output logic                  busy,
  output logic [15:0]           words_sent
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift;
  logic [BW-1:0]         bit_cnt;
  logic [15:0]           div_cnt;
  logic                  bit_done;
  logic                  go;
  assign bit_done = div_cnt == 16'(CLKS_PER_BIT - 1);
  assign go       = enable && !fifo_empty;
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_serial  <= 1'b1;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      shift      <= '0;
    end else begin
      fifo_read <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (go) begin
            state     <= READ;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end
        end
        READ: state <= LOAD;
        // fifo_out is valid only during this cycle, one after the popping edge
        LOAD: begin
          shift     <= fifo_out;
          tx_serial <= 1'b0;
          div_cnt   <= '0;
          state     <= START;
        end
        START: begin
          div_cnt <= bit_done ? '0 : div_cnt + 16'd1;
          if (bit_done) begin
            tx_serial <= shift[0];
            bit_cnt   <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          div_cnt <= bit_done ? '0 : div_cnt + 16'd1;
          if (bit_done && bit_cnt == BW'(DATA_WIDTH - 1)) begin
            tx_serial <= 1'b1;
            state     <= STOP;
          end else if (bit_done) begin
            shift     <= shift >> 1;
            tx_serial <= shift[1];
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          div_cnt <= bit_done ? '0 : div_cnt + 16'd1;
          if (bit_done) begin
            words_sent <= words_sent + 16'd1;
            state      <= go ? READ : IDLE;
            fifo_read  <= go;
            busy       <= go;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
